// File: rtl/host_loader.sv
// Host-side loader: streams a program into the processor memory, runs the
// processor for a fixed number of cycles, then reads registers r0..r7 back
// through a valid/ready result port.
module host_loader #(
  parameter int DEPTH      = 32,
  parameter int RUN_CYCLES = 155
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        prog_valid,
  output logic        prog_ready,
  input  logic [31:0] prog_data,
  input  logic        prog_last,
  output logic [31:0] addr,
  output logic        wr,
  output logic [31:0] wdata,
  output logic        working,
  output logic [3:0]  rID,
  input  logic [31:0] rdata,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [2:0]  res_id,
  output logic        busy,
  output logic        done,
  output logic        err_ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES + 1) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(RUN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_GAP, S_RUN, S_DRAIN, S_READ, S_WAIT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] run_q, run_d;
  logic          drain_q, drain_d;
  logic [31:0]   addr_q, addr_d;
  logic          wr_q, wr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          working_q, working_d;
  logic [3:0]    rid_q, rid_d;
  logic          res_valid_q, res_valid_d;
  logic [31:0]   res_data_q, res_data_d;
  logic [2:0]    res_id_q, res_id_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  // Next-state and registered-output decode; the word counter stops at the
  // last index so the load address can never exceed DEPTH-1.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_d       = run_q;
    drain_d     = drain_q;
    addr_d      = addr_q;
    wr_d        = 1'b0;
    wdata_d     = wdata_q;
    working_d   = 1'b0;
    rid_d       = rid_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    done_d      = 1'b0;
    err_d       = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (prog_valid) begin
          wr_d    = 1'b1;
          addr_d  = 32'(cnt_q);
          wdata_d = prog_data;
          if (prog_last || cnt_q == LAST_IDX) begin
            if (!prog_last) err_d = 1'b1;
            state_d = S_GAP;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      S_GAP: begin
        addr_d    = '0;
        wdata_d   = '0;
        run_d     = '0;
        working_d = 1'b1;
        state_d   = S_RUN;
      end
      S_RUN: begin
        if (run_q == RUN_LAST) begin
          drain_d = 1'b0;
          state_d = S_DRAIN;
        end else begin
          working_d = 1'b1;
          run_d     = run_q + RW'(1);
        end
      end
      S_DRAIN: begin
        if (!drain_q) begin
          drain_d = 1'b1;
          rid_d   = 4'h0;
        end else begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        res_data_d  = rdata;
        res_id_d    = rid_q[2:0];
        res_valid_d = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (rid_q == 4'h7) begin
            rid_d   = 4'hF;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            rid_d   = rid_q + 4'h1;
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      run_q       <= '0;
      drain_q     <= 1'b0;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      working_q   <= 1'b0;
      rid_q       <= 4'hF;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_q       <= run_d;
      drain_q     <= drain_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      working_q   <= working_d;
      rid_q       <= rid_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign prog_ready = (state_q == S_LOAD);
  assign busy       = (state_q != S_IDLE);
  assign addr       = addr_q;
  assign wr         = wr_q;
  assign wdata      = wdata_q;
  assign working    = working_q;
  assign rID        = rid_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_id     = res_id_q;
  assign done       = done_q;
  assign err_ovf    = err_q;

endmodule

// File: tb/tb_host_loader.sv
// Directed bench for host_loader: normal load/run/readback, result stall,
// program overflow, reset during RUN, and ignored stray inputs.
module tb_host_loader;

  localparam int DEPTH      = 32;
  localparam int RUN_CYCLES = 155;

  logic        clock = 1'b0;
  logic        reset, start, prog_valid, prog_last, res_ready;
  logic [31:0] prog_data, rdata;
  logic        prog_ready, wr, working, res_valid, busy, done, err_ovf;
  logic [31:0] addr, wdata, res_data;
  logic [3:0]  rID;
  logic [2:0]  res_id;

  logic [31:0] regs [8];
  logic [31:0] words [64];
  int n_checks = 0;
  int n_fails  = 0;

  host_loader #(.DEPTH(DEPTH), .RUN_CYCLES(RUN_CYCLES)) dut (
    .clock(clock), .reset(reset), .start(start),
    .prog_valid(prog_valid), .prog_ready(prog_ready), .prog_data(prog_data),
    .prog_last(prog_last), .addr(addr), .wr(wr), .wdata(wdata),
    .working(working), .rID(rID), .rdata(rdata), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
    .busy(busy), .done(done), .err_ovf(err_ovf)
  );

  always #5 clock = ~clock;

  // Processor register file model: combinational read by rID.
  assign rdata = rID[3] ? 32'hDEAD_BEEF : regs[rID[2:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_addr"}, addr, 0);
    chk({p, "_wr"}, wr, 0);
    chk({p, "_wdata"}, wdata, 0);
    chk({p, "_working"}, working, 0);
    chk({p, "_rid"}, rID, 4'hF);
    chk({p, "_res_valid"}, res_valid, 0);
    chk({p, "_res_data"}, res_data, 0);
    chk({p, "_res_id"}, res_id, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_err"}, err_ovf, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_ready"}, prog_ready, 0);
  endtask

  // Start a session and offer n words back to back; ends at the GAP sample.
  task automatic start_load(input int n, input bit with_last);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("load_ready", prog_ready, 1);
    chk("load_busy", busy, 1);
    chk("load_err_clear", err_ovf, 0);
    for (int i = 0; i < n; i++) begin
      prog_valid = 1'b1;
      prog_data  = words[i];
      prog_last  = with_last && (i == n - 1);
      chk("ready_in_load", prog_ready, 1);
      step();
      chk("wr_pulse", wr, 1);
      chk("wr_addr", addr, i);
      chk("wr_data", wdata, words[i]);
    end
    prog_valid = 1'b0;
    prog_last  = 1'b0;
    chk("gap_working", working, 0);
    chk("gap_ready", prog_ready, 0);
  endtask

  // From the GAP sample: count working cycles, optionally pulse start.
  task automatic run_phase(input int pulse_at);
    int wcnt = 0;
    int bad  = 0;
    step();
    prog_valid = 1'b0;
    prog_last  = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!working) break;
      wcnt++;
      if (wr !== 1'b0 || addr !== 32'd0 || busy !== 1'b1) bad++;
      start = (wcnt == pulse_at);
      step();
    end
    start = 1'b0;
    chk("run_length", wcnt, RUN_CYCLES);
    chk("run_no_wr", bad, 0);
  endtask

  // From the first DRAIN sample: collect results until done.
  task automatic readback(input int stall_id, input bit toggle_pv);
    logic [31:0] rd_data [8];
    int          rd_id [8];
    logic [31:0] snap_d;
    logic [2:0]  snap_i;
    int got = 0, bad = 0, stall_n = 0;
    bit stalled = 0, stall_act = 0, fin = 0;
    res_ready = 1'b1;
    for (int c = 0; c < 200 && !fin; c++) begin
      step();
      if (toggle_pv) begin
        prog_valid = ~prog_valid;
        prog_data  = $urandom;
        prog_last  = prog_valid;
      end
      if (wr) bad++;
      if (done) begin
        chk("done_rid", rID, 4'hF);
        fin = 1;
      end
      if (res_valid && res_id == stall_id && !stalled) begin
        stalled = 1; stall_act = 1; stall_n = 1;
        res_ready = 1'b0;
        snap_d = res_data;
        snap_i = res_id;
      end else if (stall_act) begin
        chk("stall_valid", res_valid, 1);
        chk("stall_data", res_data, snap_d);
        chk("stall_id", res_id, snap_i);
        if (stall_n == 5) begin
          res_ready = 1'b1;
          stall_act = 0;
        end else begin
          stall_n++;
        end
      end
      if (res_valid && res_ready) begin
        if (got < 8) begin
          rd_data[got] = res_data;
          rd_id[got]   = res_id;
        end
        got++;
      end
    end
    prog_valid = 1'b0;
    prog_last  = 1'b0;
    chk("done_seen", fin, 1);
    chk("result_count", got, 8);
    chk("readback_no_wr", bad, 0);
    for (int i = 0; i < 8 && i < got; i++) begin
      chk("result_id", rd_id[i], i);
      chk("result_data", rd_data[i], regs[i]);
    end
    if (stall_id >= 0) chk("stall_happened", stalled, 1);
    step();
    chk("done_one_pulse", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_rid", rID, 4'hF);
    chk("idle_res_valid", res_valid, 0);
  endtask

  initial begin
    int v, b;
    reset = 1'b1; start = 1'b0; prog_valid = 1'b0; prog_last = 1'b0;
    prog_data = '0; res_ready = 1'b1;
    foreach (regs[i]) regs[i] = '0;
    #2 reset = 1'b0;
    #2 chk_reset_vals("por");
    step();
    reset = 1'b1;
    step();
    chk_reset_vals("idle");

    // Session 1: three-word program, r0=1 r1=2, stall on id 3.
    words[0] = 32'h10F0_0001; words[1] = 32'h10F1_0002; words[2] = 32'h1100_0000;
    regs[0] = 32'd1; regs[1] = 32'd2;
    start_load(3, 1'b1);
    chk("s1_err", err_ovf, 0);
    run_phase(-1);
    readback(3, 1'b0);

    // Session 2: overflow, start pulsed in RUN, prog_valid toggled in readback.
    for (int i = 0; i < 33; i++) words[i] = 32'h0000_0100 + i;
    for (int i = 0; i < 8; i++) regs[i] = 32'hC0DE_0000 + i * 17;
    start_load(DEPTH, 1'b0);
    chk("ovf_err", err_ovf, 1);
    prog_valid = 1'b1;
    prog_data  = words[32];
    chk("ovf_33rd_ready", prog_ready, 0);
    run_phase(20);
    readback(-1, 1'b1);
    chk("ovf_err_sticky", err_ovf, 1);

    // Session 3: reset at RUN cycle 50.
    words[0] = 32'hABCD_0001;
    start_load(1, 1'b1);
    step();
    for (int i = 1; i < 50; i++) step();
    chk("pre_reset_working", working, 1);
    #2 reset = 1'b0;
    #1 chk_reset_vals("midrun");
    step();
    step();
    reset = 1'b1;
    v = 0; b = 0;
    for (int c = 0; c < 300; c++) begin
      step();
      if (res_valid) v++;
      if (busy) b++;
    end
    chk("post_reset_no_result", v, 0);
    chk("post_reset_idle", b, 0);

    // Session 4: clean session after reset.
    words[0] = 32'h2222_0000; words[1] = 32'h3333_0001;
    for (int i = 0; i < 8; i++) regs[i] = 32'h5A5A_0000 + i;
    start_load(2, 1'b1);
    chk("s4_err", err_ovf, 0);
    run_phase(-1);
    readback(-1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
